// File: rtl/bus_master_if.sv
// ---------------------------------------------------------------------------
// bus_master_if
//
// Master-side bus interface unit. Converts a single-cycle access request from
// a core (CPU, DMA) into a complete shared-bus transaction:
//   IDLE   -> latch the request, raise bus_req
//   REQ    -> wait (without limit) for bus_grnt
//   ACCESS -> drive bus_as with stable address/data until bus_rdy, a ready
//             timeout, or a lost grant ends the transfer
// A completion pulse (core_done, plus core_err on abort) is returned to the
// core. For reads, the returned data is held on core_rd_data until the next
// read completes.
//
// Ports
//   clk           in   system clock
//   rest          in   synchronous, active-high reset
//   core_req      in   access request, only sampled in IDLE
//   core_addr     in   access address, sampled with core_req
//   core_rw       in   1 = read, 0 = write, sampled with core_req
//   core_wr_data  in   write data, sampled with core_req
//   core_busy     out  high whenever the unit is not IDLE (decoded from state)
//   core_done     out  one-cycle completion pulse
//   core_err      out  one-cycle abort flag, coincident with core_done
//   core_rd_data  out  last completed read data
//   bus_req       out  bus request to the arbiter
//   bus_grnt      in   grant from the arbiter
//   bus_addr      out  bus address
//   bus_as        out  address strobe, active high
//   bus_rw        out  1 = read, 0 = write
//   bus_wr_data   out  write data to the bus
//   bus_rdy       in   shared slave ready, active high
//   bus_rd_data   in   shared slave read data
// ---------------------------------------------------------------------------
module bus_master_if #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              core_req,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_rw,
    input  logic [DATA_W-1:0] core_wr_data,
    output logic              core_busy,
    output logic              core_done,
    output logic              core_err,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              bus_req,
    input  logic              bus_grnt,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic              bus_rdy,
    input  logic [DATA_W-1:0] bus_rd_data
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // TIMEOUT is at most 255, so an 8-bit counter suffices; the compare is
    // done one bit wider so cnt_q + 1 can never wrap.
    localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

    logic [1:0]        state_q,        state_d;
    logic [7:0]        cnt_q,          cnt_d;
    logic              bus_req_q,      bus_req_d;
    logic              bus_as_q,       bus_as_d;
    logic              bus_rw_q,       bus_rw_d;
    logic [ADDR_W-1:0] bus_addr_q,     bus_addr_d;
    logic [DATA_W-1:0] bus_wr_data_q,  bus_wr_data_d;
    logic              core_done_q,    core_done_d;
    logic              core_err_q,     core_err_d;
    logic [DATA_W-1:0] core_rd_data_q, core_rd_data_d;

    logic [8:0]        cnt_inc_s;
    logic              timeout_hit_s;

    assign cnt_inc_s     = {1'b0, cnt_q} + 9'd1;
    // This ACCESS cycle is the TIMEOUT-th one without ready.
    assign timeout_hit_s = (cnt_inc_s >= TIMEOUT_LIM);

    // Next-state and next-output computation for the transaction sequencer.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bus_req_d      = bus_req_q;
        bus_as_d       = bus_as_q;
        bus_rw_d       = bus_rw_q;
        bus_addr_d     = bus_addr_q;
        bus_wr_data_d  = bus_wr_data_q;
        core_done_d    = 1'b0;
        core_err_d     = 1'b0;
        core_rd_data_d = core_rd_data_q;

        case (state_q)
            ST_IDLE: begin
                bus_as_d = 1'b0;
                if (core_req) begin
                    bus_addr_d    = core_addr;
                    bus_rw_d      = core_rw;
                    bus_wr_data_d = core_wr_data;
                    bus_req_d     = 1'b1;
                    state_d       = ST_REQ;
                end else begin
                    bus_req_d     = 1'b0;
                end
            end

            ST_REQ: begin
                bus_req_d = 1'b1;
                if (bus_grnt) begin
                    bus_as_d = 1'b1;
                    cnt_d    = 8'd0;
                    state_d  = ST_ACCESS;
                end else begin
                    bus_as_d = 1'b0;
                end
            end

            ST_ACCESS: begin
                // Ready takes priority over a simultaneous timeout/lost grant.
                if (bus_rdy) begin
                    bus_as_d    = 1'b0;
                    bus_req_d   = 1'b0;
                    core_done_d = 1'b1;
                    state_d     = ST_IDLE;
                    if (bus_rw_q) begin
                        core_rd_data_d = bus_rd_data;
                    end else begin
                        core_rd_data_d = core_rd_data_q;
                    end
                end else if (!bus_grnt || timeout_hit_s) begin
                    bus_as_d    = 1'b0;
                    bus_req_d   = 1'b0;
                    core_done_d = 1'b1;
                    core_err_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    bus_as_d  = 1'b1;
                    bus_req_d = 1'b1;
                    cnt_d     = cnt_inc_s[7:0];
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
                bus_as_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rest) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 8'd0;
            bus_req_q      <= 1'b0;
            bus_as_q       <= 1'b0;
            bus_rw_q       <= 1'b1;
            bus_addr_q     <= {ADDR_W{1'b0}};
            bus_wr_data_q  <= {DATA_W{1'b0}};
            core_done_q    <= 1'b0;
            core_err_q     <= 1'b0;
            core_rd_data_q <= {DATA_W{1'b0}};
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bus_req_q      <= bus_req_d;
            bus_as_q       <= bus_as_d;
            bus_rw_q       <= bus_rw_d;
            bus_addr_q     <= bus_addr_d;
            bus_wr_data_q  <= bus_wr_data_d;
            core_done_q    <= core_done_d;
            core_err_q     <= core_err_d;
            core_rd_data_q <= core_rd_data_d;
        end
    end

    assign core_busy    = (state_q != ST_IDLE);
    assign core_done    = core_done_q;
    assign core_err     = core_err_q;
    assign core_rd_data = core_rd_data_q;
    assign bus_req      = bus_req_q;
    assign bus_as       = bus_as_q;
    assign bus_rw       = bus_rw_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wr_data  = bus_wr_data_q;

endmodule

// File: tb/tb_bus_master_if.sv
// ---------------------------------------------------------------------------
// tb_bus_master_if
//
// Scoreboard bench for bus_master_if. Each issued request pushes its expected
// outcome (error flag, returned read data, strobe length, latched bus fields)
// computed at transaction level from the slave/arbiter behaviour chosen for
// it. A monitor pops and compares on every core_done. Directed cycle checks
// cover latency, grant delay, timeout, reset mid-access and back-to-back.
// ---------------------------------------------------------------------------
module tb_bus_master_if;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rest = 1'b1;
    logic          core_req = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic          core_rw = 1'b0;
    logic [DW-1:0] core_wr_data = '0;
    logic          core_busy, core_done, core_err;
    logic [DW-1:0] core_rd_data;
    logic          bus_req;
    logic          bus_grnt = 1'b0;
    logic [AW-1:0] bus_addr;
    logic          bus_as, bus_rw;
    logic [DW-1:0] bus_wr_data;
    logic          bus_rdy = 1'b0;
    logic [DW-1:0] bus_rd_data = '0;

    bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rest(rest),
        .core_req(core_req), .core_addr(core_addr), .core_rw(core_rw),
        .core_wr_data(core_wr_data), .core_busy(core_busy),
        .core_done(core_done), .core_err(core_err),
        .core_rd_data(core_rd_data),
        .bus_req(bus_req), .bus_grnt(bus_grnt), .bus_addr(bus_addr),
        .bus_as(bus_as), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
        .bus_rdy(bus_rdy), .bus_rd_data(bus_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          err;
        logic [DW-1:0] rd;
        int            as_len;
        logic [AW-1:0] addr;
        logic          rw;
        logic [DW-1:0] wd;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] last_rd = '0;
    int            checks = 0;
    int            errors = 0;

    // Slave / arbiter behaviour for the current transaction
    int slv_waits = 0;
    int gnt_delay = 0;
    bit gnt_drop  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave and arbiter models, updated just after each rising edge.
    initial begin
        int slv_cnt = 0;
        int gnt_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rest || !bus_as) begin
                slv_cnt = 0;
                bus_rdy = 1'b0;
            end else begin
                bus_rdy = (slv_cnt >= slv_waits);
                slv_cnt++;
            end
            if (rest || !bus_req) begin
                gnt_cnt  = 0;
                bus_grnt = 1'b0;
            end else if (gnt_drop && bus_as) begin
                bus_grnt = 1'b0;
            end else begin
                bus_grnt = (gnt_cnt >= gnt_delay);
                gnt_cnt++;
            end
        end
    end

    // Drive one request (accepted at the next rising edge) and push its
    // expected outcome, derived from the slave/arbiter settings.
    task automatic issue(input logic [AW-1:0] addr, input logic rw,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                         input int waits, input int gdly, input bit drop);
        exp_t e;
        slv_waits   = waits;
        gnt_delay   = gdly;
        gnt_drop    = drop;
        bus_rd_data = rd;
        e.addr = addr;
        e.rw   = rw;
        e.wd   = wd;
        if (drop && waits > 0) begin
            e.err    = 1'b1;
            e.as_len = 1;
        end else if (waits >= TO) begin
            e.err    = 1'b1;
            e.as_len = TO;
        end else begin
            e.err    = 1'b0;
            e.as_len = waits + 1;
        end
        if (!e.err && rw) last_rd = rd;
        e.rd = last_rd;
        sb_q.push_back(e);
        core_req     = 1'b1;
        core_addr    = addr;
        core_rw      = rw;
        core_wr_data = wd;
        @(posedge clk);
        #1;
        core_req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (core_done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    // Monitor: strobe length and field stability, scoreboard pop on done.
    initial begin
        int as_cnt   = 0;
        bit stab_bad = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rest) begin
                as_cnt   = 0;
                stab_bad = 1'b0;
            end else begin
                if (bus_as) begin
                    as_cnt++;
                    if (sb_q.size() > 0 &&
                        (bus_addr !== sb_q[0].addr || bus_rw !== sb_q[0].rw ||
                         bus_wr_data !== sb_q[0].wd))
                        stab_bad = 1'b1;
                end
                if (core_err && !core_done)
                    check("err_without_done", 64'(core_err), 64'd0);
                if (core_done) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 64'(core_done), 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_err",      64'(core_err),     64'(e.err));
                        check("sb_rd_data",  64'(core_rd_data), 64'(e.rd));
                        check("sb_as_len",   64'(as_cnt),       64'(e.as_len));
                        check("sb_stable",   64'(stab_bad),     64'd0);
                        check("sb_busy",     64'(core_busy),    64'd0);
                        check("sb_req_drop", 64'(bus_req),      64'd0);
                    end
                    as_cnt   = 0;
                    stab_bad = 1'b0;
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_bus_req",  64'(bus_req),      64'd0);
        check("rst_bus_as",   64'(bus_as),       64'd0);
        check("rst_bus_rw",   64'(bus_rw),       64'd1);
        check("rst_bus_addr", 64'(bus_addr),     64'd0);
        check("rst_wr_data",  64'(bus_wr_data),  64'd0);
        check("rst_rd_data",  64'(core_rd_data), 64'd0);
        check("rst_done",     64'(core_done),    64'd0);
        check("rst_busy",     64'(core_busy),    64'd0);
        rest = 1'b0;
        repeat (2) @(negedge clk);

        // Zero-wait read: bus_req at T1, bus_as only at T2, done at T3
        issue(30'h0000_0004, 1'b1, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
        @(negedge clk);
        check("zw_t1_req", 64'(bus_req), 64'd1);
        check("zw_t1_as",  64'(bus_as),  64'd0);
        @(negedge clk);
        check("zw_t2_as",  64'(bus_as),  64'd1);
        @(negedge clk);
        check("zw_t3_as",   64'(bus_as),       64'd0);
        check("zw_t3_done", 64'(core_done),    64'd1);
        check("zw_t3_rd",   64'(core_rd_data), 64'hDEAD_BEEF);
        check("zw_t3_busy", 64'(core_busy),    64'd0);
        check("zw_t3_req",  64'(bus_req),      64'd0);

        // Back-to-back waited write, issued in the done cycle
        issue(30'h0000_0100, 1'b0, 32'h1234_5678, 32'h5555_5555, 3, 0, 1'b0);
        @(negedge clk);
        check("b2b_req_back", 64'(bus_req), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ww_as_high", 64'(bus_as),      64'd1);
            check("ww_wr_data", 64'(bus_wr_data), 64'h1234_5678);
        end
        @(negedge clk);
        check("ww_done", 64'(core_done),    64'd1);
        check("ww_err",  64'(core_err),     64'd0);
        check("ww_rd",   64'(core_rd_data), 64'hDEAD_BEEF);

        // Grant withheld 5 cycles; requests while busy are ignored
        repeat (2) @(negedge clk);
        issue(30'h0ABC_DEF0, 1'b1, 32'h0, 32'hCAFE_F00D, 1, 5, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("gd_req_held", 64'(bus_req), 64'd1);
            check("gd_as_low",   64'(bus_as),  64'd0);
            core_req  = 1'b1;
            core_addr = 30'h3FFF_FFFF;
        end
        core_req = 1'b0;
        @(negedge clk);
        check("gd_as_rise", 64'(bus_as), 64'd1);
        wait_done("gd");

        // Timeout with a slave that never readies
        repeat (2) @(negedge clk);
        issue(30'h0000_0200, 1'b1, 32'h0, 32'h0BAD_0BAD, 1000, 0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            check("to_as_high", 64'(bus_as), 64'd1);
        end
        @(negedge clk);
        check("to_done", 64'(core_done), 64'd1);
        check("to_err",  64'(core_err),  64'd1);
        check("to_req",  64'(bus_req),   64'd0);
        check("to_busy", 64'(core_busy), 64'd0);

        // Reset during the second ACCESS cycle: no completion, idle outputs
        repeat (2) @(negedge clk);
        issue(30'h0000_0300, 1'b0, 32'hAAAA_5555, 32'h0, 10, 0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rest = 1'b1;
        @(posedge clk);
        #1 rest = 1'b0;
        sb_q.delete();
        last_rd = '0;
        @(negedge clk);
        check("rma_req",  64'(bus_req),      64'd0);
        check("rma_as",   64'(bus_as),       64'd0);
        check("rma_rw",   64'(bus_rw),       64'd1);
        check("rma_done", 64'(core_done),    64'd0);
        check("rma_busy", 64'(core_busy),    64'd0);
        check("rma_rd",   64'(core_rd_data), 64'd0);

        // Fresh read after reset
        @(negedge clk);
        issue(30'h0000_0008, 1'b1, 32'h0, 32'h8765_4321, 2, 1, 1'b0);
        wait_done("post_rst");
        check("post_rst_rd", 64'(core_rd_data), 64'h8765_4321);

        // Randomized transactions, some back-to-back, some with gaps
        for (int i = 0; i < 40; i++) begin
            issue(AW'($urandom), 1'($urandom_range(0, 1)), $urandom, $urandom,
                  $urandom_range(0, 5), $urandom_range(0, 3),
                  ($urandom_range(0, 7) == 0));
            wait_done("rnd");
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
